// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming-distance / popcount core.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_POP = 1'b0;
  localparam logic MODE_HAM = 1'b1;

  // Widest chunk the counting helper supports.
  localparam int MAX_CHUNK_WIDTH = 64;

  function automatic int unsigned chunk_popcount(
    input logic [MAX_CHUNK_WIDTH-1:0] bits,
    input int unsigned                width
  );
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_CHUNK_WIDTH; i++) begin
      if (i < width && bits[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hamming_chunk_count.sv
// Combinational popcount of one CHUNK_WIDTH-bit slice of the working operand.
module hamming_chunk_count
  import hamming_pkg::*;
#(
  parameter int CHUNK_WIDTH = 8,
  parameter int CNT_W       = $clog2(CHUNK_WIDTH + 1)
) (
  input  logic [CHUNK_WIDTH-1:0] i_chunk,
  output logic [CNT_W-1:0]       o_count
);

  if (CHUNK_WIDTH > MAX_CHUNK_WIDTH) begin : g_bad_width
    $error("hamming_chunk_count: CHUNK_WIDTH exceeds MAX_CHUNK_WIDTH");
  end

  logic [MAX_CHUNK_WIDTH-1:0] w_bits;

  assign w_bits  = MAX_CHUNK_WIDTH'(i_chunk);
  assign o_count = CNT_W'(chunk_popcount(w_bits, CHUNK_WIDTH));

endmodule

// File: rtl/hamming_pop_core.sv
// Sequential popcount / Hamming-distance core: one CHUNK_WIDTH slice per cycle,
// LSB chunk first, with busy/done/result_valid status for the register slave.
module hamming_pop_core
  import hamming_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int RES_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  mode,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  output logic [RES_WIDTH-1:0]  result
);

  if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
    $error("hamming_pop_core: CHUNK_WIDTH must divide DATA_WIDTH");
  end

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int CNT_W      = $clog2(CHUNK_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_accept;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] r_work;
  logic [IDX_W-1:0]      r_idx;
  logic [RES_WIDTH-1:0]  r_acc;
  logic [RES_WIDTH-1:0]  r_result;
  logic [RES_WIDTH-1:0]  w_acc_sum;
  logic [CNT_W-1:0]      w_chunk_cnt;
  logic                  r_result_valid;

  // A start arriving while counting is dropped, not queued.
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

  hamming_chunk_count #(
    .CHUNK_WIDTH(CHUNK_WIDTH),
    .CNT_W      (CNT_W)
  ) u_chunk_count (
    .i_chunk(r_work[CHUNK_WIDTH-1:0]),
    .o_count(w_chunk_cnt)
  );

  assign w_acc_sum = r_acc + RES_WIDTH'(w_chunk_cnt);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through the case leaves the
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = start ? RUN : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // DONE lasts exactly one cycle, so its decode is the done pulse.
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // The working copy shifts right each cycle so the active chunk is always at the LSBs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_work         <= '0;
      r_idx          <= '0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else if (w_accept) begin
      r_work         <= (mode == MODE_HAM) ? (op_a ^ op_b) : op_a;
      r_idx          <= '0;
      r_acc          <= '0;
      r_result_valid <= 1'b0;
    end else if (r_state == RUN) begin
      r_work <= r_work >> CHUNK_WIDTH;
      r_idx  <= r_idx + IDX_W'(1);
      r_acc  <= w_acc_sum;
      if (w_last) begin
        r_result       <= w_acc_sum;
        r_result_valid <= 1'b1;
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule
